byte_sub: RTL and testbench
===========================

BYTE_SUB -- requirements
Module: byte_sub

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-003 Port rst: input, 1 bit, synchronous active-high reset.
REQ-004 Port plaintext: input, 8 bits, byte to be substituted.
REQ-005 Port in_valid: input, 1 bit, plaintext is valid this cycle.
REQ-006 Port substitutedText: output, 8 bits, AES S-box image of the captured byte.
REQ-007 Port out_valid: output, 1 bit, substitutedText is valid this cycle.
REQ-008 The block SHALL have no parameters; the data width is fixed at 8 bits.

Function
REQ-009 The block SHALL implement the AES (FIPS-197) forward S-box SubBytes mapping for all 256 input values.
- Multiplicative inverse in GF(2^8), modulo x^8+x^4+x^3+x+1, with 0 mapping to 0.
- Followed by the affine transform with constant 0x63.
REQ-010 The result SHALL be registered with a latency of exactly 1 clock cycle.
- If in_valid=1 at rising edge N, then from edge N onward: substitutedText=S(plaintext) and out_valid=1.
REQ-011 If in_valid=0 at an edge, out_valid SHALL go 0 at that edge and substitutedText SHALL hold its previous value.
REQ-012 Back-to-back inputs on consecutive cycles SHALL be accepted at a throughput of one byte per cycle, with no stall and no backpressure.
REQ-013 The output SHALL depend only on the captured byte; the block SHALL hold no other history and SHALL contain no combinational path from input to output.
REQ-014 Mandatory table points:
- S(0x00)=0x63, S(0x01)=0x7C, S(0x10)=0xCA
- S(0x35)=0x96, S(0x53)=0xED, S(0xFF)=0x16
REQ-015 X or Z on plaintext while in_valid=0 SHALL NOT propagate to out_valid.

Reset
REQ-016 While rst=1 at a rising edge, substitutedText SHALL become 0x00 and out_valid SHALL become 0.
REQ-017 Reset SHALL take priority over in_valid; an input presented in a reset cycle SHALL be discarded.
REQ-018 Reset asserted mid-stream SHALL drop any pending result, with no output pulse after reset.
REQ-019 In the first edge after rst falls, a valid input SHALL be accepted normally.

Structure
REQ-020 The 256-entry S-box constant table SHALL reside in a shared package (aes_pkg), so that the inverse S-box and other AES blocks can share it.
REQ-021 A combinational sub-module aes_sbox (8-bit in, 8-bit out, table lookup) SHALL perform the mapping.
REQ-022 byte_sub SHALL wrap aes_sbox with the output register and the valid register.
REQ-023 The design SHALL be synthesizable, with no latches and a single clock domain.

Verification
REQ-024 Reset: rst=1 for 2 cycles, with in_valid=1 and plaintext=0x35 -> substitutedText=0x00 and out_valid=0 throughout.
REQ-025 Single transfer: in_valid=1 with plaintext=0x35, then plaintext=0x00 -> 0x96 then 0x63, each one cycle after input, with out_valid=1.
REQ-026 Streaming: plaintext 0x01, 0x10, 0x53, 0xFF on consecutive cycles -> 0x7C, 0xCA, 0xED, 0x16 on consecutive cycles.
REQ-027 Hold: in_valid drops after 0x53 -> out_valid=0 and substitutedText holds 0xED.
REQ-028 Mid-stream reset: rst=1 for one cycle during a stream -> output goes to 0x00/0 at that edge, and the stream resumes at the next valid input.
REQ-029 Exhaustive check: all 256 inputs compared against a reference model computed by GF(2^8) inversion plus affine transform -> zero mismatches.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: the forward S-box table and a lookup helper.
// The inverse S-box and other AES datapath blocks import this package.
package aes_pkg;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: pure table lookup, no state.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    always_comb begin
        sbox_out = sbox_fwd(sbox_in);
    end

endmodule

// File: rtl/byte_sub.sv
// Single-byte AES SubBytes stage: S-box lookup followed by one register,
// one result per cycle, no backpressure.
module byte_sub (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] plaintext,
    input  logic       in_valid,
    output logic [7:0] substitutedText,
    output logic       out_valid
);

    logic [7:0] sub_byte;
    logic [7:0] text_d;
    logic [7:0] text_q;
    logic       valid_d;
    logic       valid_q;

    aes_sbox u_sbox (
        .sbox_in  (plaintext),
        .sbox_out (sub_byte)
    );

    // Data only updates on a valid input, so X on an idle bus never reaches the valid flag.
    always_comb begin
        text_d  = text_q;
        valid_d = in_valid;
        if (in_valid) begin
            text_d = sub_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            text_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            text_q  <= text_d;
            valid_q <= valid_d;
        end
    end

    assign substitutedText = text_q;
    assign out_valid       = valid_q;

endmodule

// File: tb/tb_byte_sub.sv
// Bench for byte_sub: driver queues expected bytes, a negedge monitor pops
// and compares each valid output; reset and hold states are checked directly.
module tb_byte_sub;

    logic       clk;
    logic       rst;
    logic [7:0] plaintext;
    logic       in_valid;
    logic [7:0] substitutedText;
    logic       out_valid;

    int n_pass;
    int n_total;
    logic mon_en;
    logic [7:0] exp_q [$];

    byte_sub dut (
        .clk             (clk),
        .rst             (rst),
        .plaintext       (plaintext),
        .in_valid        (in_valid),
        .substitutedText (substitutedText),
        .out_valid       (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse; it also maps 0 to 0.
    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gf_mul(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] pt,
                         input logic push, input logic [7:0] exp);
        rst       = r;
        in_valid  = v;
        plaintext = pt;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out: got %02h with out_valid=1, expected no output",
                             substitutedText);
                end else begin
                    check("scoreboard", substitutedText, exp_q.pop_front());
                end
            end else if (out_valid !== 1'b0) begin
                n_total++;
                $display("FAIL out_valid_known: got %b expected 0 or 1", out_valid);
            end
        end
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        plaintext = 8'h35;

        // Reset with a valid input present: input discarded, outputs cleared.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'h35, 1'b0, 8'h00);
            check("reset_data", substitutedText, 8'h00);
            check("reset_valid", {7'd0, out_valid}, 8'h00);
        end
        mon_en = 1'b1;

        // First edge after reset: single transfers.
        drive(1'b0, 1'b1, 8'h35, 1'b1, 8'h96);
        drive(1'b0, 1'b1, 8'h00, 1'b1, 8'h63);
        drive(1'b0, 1'b0, 8'hxx, 1'b0, 8'h00);

        // Streaming back to back.
        drive(1'b0, 1'b1, 8'h01, 1'b1, 8'h7c);
        drive(1'b0, 1'b1, 8'h10, 1'b1, 8'hca);
        drive(1'b0, 1'b1, 8'h53, 1'b1, 8'hed);
        drive(1'b0, 1'b1, 8'hff, 1'b1, 8'h16);

        // Hold: valid drops after 0x53.
        drive(1'b0, 1'b1, 8'h53, 1'b1, 8'hed);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 8'hxx, 1'b0, 8'h00);
            check("hold_valid", {7'd0, out_valid}, 8'h00);
            check("hold_data", substitutedText, 8'hed);
        end

        // Mid-stream reset: the input in the reset cycle is dropped.
        drive(1'b0, 1'b1, 8'h01, 1'b1, 8'h7c);
        drive(1'b0, 1'b1, 8'h10, 1'b1, 8'hca);
        drive(1'b1, 1'b1, 8'h53, 1'b0, 8'h00);
        check("midrst_data", substitutedText, 8'h00);
        check("midrst_valid", {7'd0, out_valid}, 8'h00);
        drive(1'b0, 1'b1, 8'hff, 1'b1, 8'h16);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("post_rst_hold", substitutedText, 8'h16);

        // All 256 inputs against the GF(2^8) reference model.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b1, ref_sbox(8'(i)));
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
